// File: rtl/pulpino_spi_master_ip_global_pkg.sv
// Shared types for the SPI master IP collector: FSM states, flag bit positions,
// packet layout and the phase-sequencing helper.
package pulpino_spi_master_ip_global_pkg;

    typedef enum logic [2:0] {
        COL_IDLE,
        COL_CMD,
        COL_ADDR,
        COL_DUMMY,
        COL_DATA,
        COL_DATA_EXTRA,
        COL_EMIT
    } col_state_e;

    localparam int FLAG_COMPLETE = 0;
    localparam int FLAG_SHORT    = 1;
    localparam int FLAG_OVERFLOW = 2;

    localparam int PKT_FIELD_W = 32;
    localparam int PKT_DUMMY_W = 16;

    typedef struct packed {
        logic [PKT_FIELD_W-1:0] cmd;
        logic [PKT_FIELD_W-1:0] addr;
        logic [PKT_DUMMY_W-1:0] dummy;
        logic [PKT_FIELD_W-1:0] data;
        logic [PKT_FIELD_W-1:0] bit_cnt;
        logic [2:0]             flag;
    } collector_pkt_t;

    // First non-empty phase after cur; later checks take priority so the
    // earliest non-empty phase wins.
    function automatic col_state_e next_phase(input col_state_e  cur,
                                              input logic [15:0] cmd_len,
                                              input logic [15:0] addr_len,
                                              input logic [15:0] dummy_len,
                                              input logic [15:0] data_len);
        col_state_e nxt;
        nxt = COL_DATA_EXTRA;
        if ((cur inside {COL_IDLE, COL_CMD, COL_ADDR, COL_DUMMY}) && (data_len != 16'd0))
            nxt = COL_DATA;
        if ((cur inside {COL_IDLE, COL_CMD, COL_ADDR}) && (dummy_len != 16'd0))
            nxt = COL_DUMMY;
        if ((cur inside {COL_IDLE, COL_CMD}) && (addr_len != 16'd0))
            nxt = COL_ADDR;
        if ((cur == COL_IDLE) && (cmd_len != 16'd0))
            nxt = COL_CMD;
        return nxt;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes the SPI pad signals into clk_i and produces SCLK-rise and
// CSN-fall/CSN-rise pulses plus the MOSI bit aligned with the SCLK rise.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic spi_clk_i,
    input  logic spi_csn_i,
    input  logic spi_mosi_i,
    output logic sclk_rise_o,
    output logic mosi_o,
    output logic csn_fall_o,
    output logic csn_rise_o
);
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   clk_prev_q;
    logic                   csn_prev_q;
    logic                   armed_q;
    logic                   clk_s;
    logic                   csn_s;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign csn_s = csn_sync_q[SYNC_STAGES-1];

    // A CSN fall only counts once CSN has been seen high with the pipeline
    // refilled after reset, so a reset released mid-frame waits for a new frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q  <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            clk_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            clk_sync_q  <= SYNC_STAGES'({clk_sync_q, spi_clk_i});
            csn_sync_q  <= SYNC_STAGES'({csn_sync_q, spi_csn_i});
            mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, spi_mosi_i});
            fill_q      <= SYNC_STAGES'({fill_q, 1'b1});
            clk_prev_q  <= clk_s;
            csn_prev_q  <= csn_s;
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & csn_s);
        end
    end

    assign sclk_rise_o = clk_s & ~clk_prev_q;
    assign mosi_o      = mosi_sync_q[SYNC_STAGES-1];
    assign csn_fall_o  = armed_q & csn_prev_q & ~csn_s;
    assign csn_rise_o  = csn_s & ~csn_prev_q;

endmodule

// File: rtl/spi_mosi_frame_collector.sv
// Rebuilds each SPI chip-select frame into a cmd/addr/dummy/data packet with
// status flags. CMD_W, ADDR_W and DATA_W must not exceed 32.
//
// state          | meaning
// COL_IDLE       | waiting for a chip-select fall
// COL_CMD        | shifting command bits
// COL_ADDR       | shifting address bits
// COL_DUMMY      | shifting dummy-phase bits
// COL_DATA       | shifting write data (first DATA_W bits kept)
// COL_DATA_EXTRA | all expected bits seen; further edges mark overflow
// COL_EMIT       | load the output register, or drop the frame if it is full
module spi_mosi_frame_collector
    import pulpino_spi_master_ip_global_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int CMD_W       = 32,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_clk_i,
    input  logic              spi_csn_i,
    input  logic              spi_mosi_i,
    input  logic [5:0]        cfg_cmd_len_i,
    input  logic [5:0]        cfg_addr_len_i,
    input  logic [15:0]       cfg_dummy_len_i,
    input  logic [15:0]       cfg_data_len_i,
    output logic              pkt_valid_o,
    input  logic              pkt_ready_i,
    output logic [CMD_W-1:0]  pkt_cmd_o,
    output logic [ADDR_W-1:0] pkt_addr_o,
    output logic [15:0]       pkt_dummy_o,
    output logic [DATA_W-1:0] pkt_data_o,
    output logic [31:0]       pkt_bit_cnt_o,
    output logic [2:0]        pkt_flag_o,
    output logic              overrun_o
);
    localparam int DCNT_W = $clog2(DATA_W + 1);

    logic              sclk_rise;
    logic              mosi_bit;
    logic              csn_fall;
    logic              csn_rise;
    col_state_e        state_q;
    col_state_e        state_d;
    logic [15:0]       cmd_len_q;
    logic [15:0]       addr_len_q;
    logic [15:0]       dummy_len_q;
    logic [15:0]       data_len_q;
    logic [15:0]       phase_cnt_q;
    logic [15:0]       next_len;
    logic [CMD_W-1:0]  cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       dummy_q;
    logic [DATA_W-1:0] data_q;
    logic [DCNT_W-1:0] data_cnt_q;
    logic [31:0]       bit_cnt_q;
    logic              complete_q;
    logic              overflow_q;
    logic              start_pend_q;
    logic              valid_q;
    logic              overrun_q;
    collector_pkt_t    out_q;
    logic              start;
    logic              active;

    function automatic logic [15:0] phase_len(input col_state_e  st,
                                              input logic [15:0] cl,
                                              input logic [15:0] al,
                                              input logic [15:0] dl,
                                              input logic [15:0] dtl);
        logic [15:0] len;
        case (st)
            COL_CMD:   len = cl;
            COL_ADDR:  len = al;
            COL_DUMMY: len = dl;
            COL_DATA:  len = dtl;
            default:   len = 16'd0;
        endcase
        return len;
    endfunction

    spi_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .spi_clk_i  (spi_clk_i),
        .spi_csn_i  (spi_csn_i),
        .spi_mosi_i (spi_mosi_i),
        .sclk_rise_o(sclk_rise),
        .mosi_o     (mosi_bit),
        .csn_fall_o (csn_fall),
        .csn_rise_o (csn_rise)
    );

    // A CSN fall seen during EMIT is remembered and starts the frame from IDLE.
    assign start  = (state_q == COL_IDLE) && (csn_fall || start_pend_q);
    assign active = state_q inside {COL_CMD, COL_ADDR, COL_DUMMY, COL_DATA, COL_DATA_EXTRA};

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= COL_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COL_IDLE: begin
                if (start)
                    state_d = next_phase(COL_IDLE, 16'(cfg_cmd_len_i), 16'(cfg_addr_len_i),
                                         cfg_dummy_len_i, cfg_data_len_i);
            end
            COL_CMD, COL_ADDR, COL_DUMMY, COL_DATA: begin
                if (csn_rise)
                    state_d = COL_EMIT;
                else if (sclk_rise && (phase_cnt_q == 16'd1))
                    state_d = next_phase(state_q, cmd_len_q, addr_len_q, dummy_len_q, data_len_q);
            end
            COL_DATA_EXTRA: begin
                if (csn_rise) state_d = COL_EMIT;
            end
            COL_EMIT: state_d = COL_IDLE;
            default:  state_d = COL_IDLE;
        endcase
    end

    assign next_len = start ? phase_len(state_d, 16'(cfg_cmd_len_i), 16'(cfg_addr_len_i),
                                        cfg_dummy_len_i, cfg_data_len_i)
                            : phase_len(state_d, cmd_len_q, addr_len_q, dummy_len_q, data_len_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_len_q    <= '0;
            addr_len_q   <= '0;
            dummy_len_q  <= '0;
            data_len_q   <= '0;
            phase_cnt_q  <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            dummy_q      <= '0;
            data_q       <= '0;
            data_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            complete_q   <= 1'b0;
            overflow_q   <= 1'b0;
            start_pend_q <= 1'b0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            out_q        <= '0;
        end else begin
            if (state_q == COL_EMIT && csn_fall) start_pend_q <= 1'b1;
            else if (state_q == COL_IDLE)        start_pend_q <= 1'b0;

            if (start) begin
                cmd_len_q   <= 16'(cfg_cmd_len_i);
                addr_len_q  <= 16'(cfg_addr_len_i);
                dummy_len_q <= cfg_dummy_len_i;
                data_len_q  <= cfg_data_len_i;
                phase_cnt_q <= next_len;
                cmd_q       <= '0;
                addr_q      <= '0;
                dummy_q     <= '0;
                data_q      <= '0;
                data_cnt_q  <= '0;
                bit_cnt_q   <= '0;
                complete_q  <= 1'b0;
                overflow_q  <= 1'b0;
            end

            if (active && sclk_rise) begin
                if (bit_cnt_q != '1) bit_cnt_q <= bit_cnt_q + 32'd1;
                case (state_q)
                    COL_CMD:   cmd_q   <= CMD_W'({cmd_q, mosi_bit});
                    COL_ADDR:  addr_q  <= ADDR_W'({addr_q, mosi_bit});
                    COL_DUMMY: dummy_q <= {dummy_q[14:0], mosi_bit};
                    COL_DATA: begin
                        if (data_cnt_q < DCNT_W'(DATA_W)) begin
                            data_q     <= DATA_W'({data_q, mosi_bit});
                            data_cnt_q <= data_cnt_q + 1'b1;
                        end
                    end
                    COL_DATA_EXTRA: overflow_q <= 1'b1;
                    default: ;
                endcase
                if (state_q != COL_DATA_EXTRA)
                    phase_cnt_q <= (phase_cnt_q == 16'd1) ? next_len : phase_cnt_q - 16'd1;
            end

            if (active && csn_rise) complete_q <= (state_q == COL_DATA_EXTRA);

            if (state_q == COL_EMIT) begin
                if (!valid_q || pkt_ready_i) begin
                    out_q.cmd                 <= PKT_FIELD_W'(cmd_q);
                    out_q.addr                <= PKT_FIELD_W'(addr_q);
                    out_q.dummy               <= dummy_q;
                    out_q.data                <= PKT_FIELD_W'(data_q);
                    out_q.bit_cnt             <= bit_cnt_q;
                    out_q.flag[FLAG_COMPLETE] <= complete_q;
                    out_q.flag[FLAG_SHORT]    <= ~complete_q;
                    out_q.flag[FLAG_OVERFLOW] <= overflow_q;
                    valid_q                   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && pkt_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign pkt_valid_o   = valid_q;
    assign pkt_cmd_o     = out_q.cmd[CMD_W-1:0];
    assign pkt_addr_o    = out_q.addr[ADDR_W-1:0];
    assign pkt_dummy_o   = out_q.dummy;
    assign pkt_data_o    = out_q.data[DATA_W-1:0];
    assign pkt_bit_cnt_o = out_q.bit_cnt;
    assign pkt_flag_o    = out_q.flag;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_spi_mosi_frame_collector.sv
// Bench for spi_mosi_frame_collector: directed and random SPI frames checked
// against a bit-index reference model of the expected packet.
module tb_spi_mosi_frame_collector;

    localparam int SYNC_STAGES = 2;

    typedef struct packed {
        logic [31:0] cmd;
        logic [31:0] addr;
        logic [15:0] dummy;
        logic [31:0] data;
        logic [31:0] bit_cnt;
        logic [2:0]  flag;
    } exp_pkt_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        pkt_ready = 1'b1;
    logic [5:0]  cfg_cmd_len = '0;
    logic [5:0]  cfg_addr_len = '0;
    logic [15:0] cfg_dummy_len = '0;
    logic [15:0] cfg_data_len = '0;
    logic        pkt_valid_o;
    logic [31:0] pkt_cmd_o;
    logic [31:0] pkt_addr_o;
    logic [15:0] pkt_dummy_o;
    logic [31:0] pkt_data_o;
    logic [31:0] pkt_bit_cnt_o;
    logic [2:0]  pkt_flag_o;
    logic        overrun_o;

    int vectors = 0;
    int miscompares = 0;
    bit frame_bits[$];

    always #5 clk_i = ~clk_i;

    spi_mosi_frame_collector #(
        .ADDR_W(32), .CMD_W(32), .DATA_W(32), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .spi_clk_i      (spi_clk),
        .spi_csn_i      (spi_csn),
        .spi_mosi_i     (spi_mosi),
        .cfg_cmd_len_i  (cfg_cmd_len),
        .cfg_addr_len_i (cfg_addr_len),
        .cfg_dummy_len_i(cfg_dummy_len),
        .cfg_data_len_i (cfg_data_len),
        .pkt_valid_o    (pkt_valid_o),
        .pkt_ready_i    (pkt_ready),
        .pkt_cmd_o      (pkt_cmd_o),
        .pkt_addr_o     (pkt_addr_o),
        .pkt_dummy_o    (pkt_dummy_o),
        .pkt_data_o     (pkt_data_o),
        .pkt_bit_cnt_o  (pkt_bit_cnt_o),
        .pkt_flag_o     (pkt_flag_o),
        .overrun_o      (overrun_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_bits(input logic [63:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) frame_bits.push_back(val[i]);
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) frame_bits.push_back(bit'($urandom_range(1, 0)));
    endtask

    task automatic set_cfg(input int cl, input int al, input int dl, input int dtl);
        cfg_cmd_len   = 6'(cl);
        cfg_addr_len  = 6'(al);
        cfg_dummy_len = 16'(dl);
        cfg_data_len  = 16'(dtl);
    endtask

    // Expected packet from bit positions: the frame is cmd | addr | dummy | data.
    function automatic exp_pkt_t model(input int cl, input int al, input int dl, input int dtl);
        exp_pkt_t e;
        int n;
        int total;
        e = '0;
        n = frame_bits.size();
        total = cl + al + dl + dtl;
        for (int i = 0; i < n; i++) begin
            if (i < cl)
                e.cmd = e.cmd * 2 + 32'(frame_bits[i]);
            else if (i < cl + al)
                e.addr = e.addr * 2 + 32'(frame_bits[i]);
            else if (i < cl + al + dl)
                e.dummy = 16'(e.dummy * 2 + 16'(frame_bits[i]));
            else if (i < cl + al + dl + ((dtl < 32) ? dtl : 32))
                e.data = e.data * 2 + 32'(frame_bits[i]);
        end
        e.bit_cnt = 32'(n);
        e.flag[0] = (n >= total);
        e.flag[1] = (n < total);
        e.flag[2] = (n > total);
        return e;
    endfunction

    task automatic send_frame(input bit raise_csn);
        @(negedge clk_i);
        spi_csn = 1'b0;
        repeat (6) @(negedge clk_i);
        foreach (frame_bits[i]) begin
            spi_mosi = frame_bits[i];
            repeat (4) @(negedge clk_i);
            spi_clk = 1'b1;
            repeat (4) @(negedge clk_i);
            spi_clk = 1'b0;
        end
        repeat (4) @(negedge clk_i);
        if (raise_csn) spi_csn = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int lat;
        lat = 0;
        while (!pkt_valid_o && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        chk({tag, ".valid"}, 64'(pkt_valid_o), 64'd1);
        chk({tag, ".latency"}, 64'(lat), 64'(SYNC_STAGES + 2));
    endtask

    task automatic check_pkt(input string tag, input exp_pkt_t e);
        chk({tag, ".cmd"},     64'(pkt_cmd_o),     64'(e.cmd));
        chk({tag, ".addr"},    64'(pkt_addr_o),    64'(e.addr));
        chk({tag, ".dummy"},   64'(pkt_dummy_o),   64'(e.dummy));
        chk({tag, ".data"},    64'(pkt_data_o),    64'(e.data));
        chk({tag, ".bit_cnt"}, 64'(pkt_bit_cnt_o), 64'(e.bit_cnt));
        chk({tag, ".flag"},    64'(pkt_flag_o),    64'(e.flag));
    endtask

    task automatic run_frame(input string tag, input int cl, input int al, input int dl, input int dtl);
        exp_pkt_t e;
        set_cfg(cl, al, dl, dtl);
        e = model(cl, al, dl, dtl);
        send_frame(1'b1);
        wait_valid(tag);
        check_pkt(tag, e);
        @(negedge clk_i);
        chk({tag, ".valid_drop"}, 64'(pkt_valid_o), 64'd0);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid"},   64'(pkt_valid_o),   64'd0);
        chk({tag, ".cmd"},     64'(pkt_cmd_o),     64'd0);
        chk({tag, ".addr"},    64'(pkt_addr_o),    64'd0);
        chk({tag, ".dummy"},   64'(pkt_dummy_o),   64'd0);
        chk({tag, ".data"},    64'(pkt_data_o),    64'd0);
        chk({tag, ".bit_cnt"}, 64'(pkt_bit_cnt_o), 64'd0);
        chk({tag, ".flag"},    64'(pkt_flag_o),    64'd0);
        chk({tag, ".overrun"}, 64'(overrun_o),     64'd0);
    endtask

    initial begin
        exp_pkt_t exp_a;
        int cl, al, dl, dtl, n, seen;

        repeat (5) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);

        // Full frame: cmd 0x0B, addr 0xDEADBEEF, data 0x12345678
        frame_bits.delete();
        push_bits(64'h0B, 8);
        push_bits(64'hDEADBEEF, 32);
        push_bits(64'h12345678, 32);
        run_frame("full", 8, 32, 0, 32);
        chk("full.lit_data", 64'(pkt_data_o), 64'h12345678);

        // Dummy phase with MOSI held high
        frame_bits.delete();
        push_random(8);
        push_random(24);
        push_bits(64'hFF, 8);
        push_random(16);
        run_frame("dummy", 8, 24, 8, 16);
        chk("dummy.lit_dummy", 64'(pkt_dummy_o), 64'hFF);

        // Short frame: CSN rises after 20 bits, mid-address
        frame_bits.delete();
        push_bits(64'h0B, 8);
        push_bits(64'hDEADBEEF, 32);
        frame_bits = frame_bits[0:19];
        run_frame("short", 8, 32, 0, 32);
        chk("short.lit_addr", 64'(pkt_addr_o), 64'hDEA);

        // Overflow: 40 data bits against a 32-bit data phase
        frame_bits.delete();
        push_random(8);
        push_random(32);
        push_random(40);
        run_frame("ovf", 8, 32, 0, 32);

        // All phases empty: every edge is an extra edge
        frame_bits.delete();
        push_random(3);
        run_frame("zero_len", 0, 0, 0, 0);

        for (int k = 0; k < 10; k++) begin
            cl  = int'($urandom_range(32, 0));
            al  = int'($urandom_range(32, 0));
            dl  = int'($urandom_range(20, 0));
            dtl = int'($urandom_range(40, 0));
            n   = int'($urandom_range(cl + al + dl + dtl + 8, 0));
            frame_bits.delete();
            push_random(n);
            run_frame($sformatf("rand%0d", k), cl, al, dl, dtl);
        end
        chk("rand.overrun", 64'(overrun_o), 64'd0);

        // Consumer stalls across two frames: first held, second dropped
        pkt_ready = 1'b0;
        set_cfg(8, 8, 0, 8);
        frame_bits.delete();
        push_random(24);
        exp_a = model(8, 8, 0, 8);
        send_frame(1'b1);
        wait_valid("stall_a");
        check_pkt("stall_a", exp_a);
        frame_bits.delete();
        push_random(24);
        send_frame(1'b1);
        repeat (12) @(negedge clk_i);
        chk("stall.valid_held", 64'(pkt_valid_o), 64'd1);
        chk("stall.overrun", 64'(overrun_o), 64'd1);
        check_pkt("stall_hold", exp_a);
        pkt_ready = 1'b1;
        @(negedge clk_i);
        chk("stall.valid_drop", 64'(pkt_valid_o), 64'd0);
        repeat (3) @(negedge clk_i);

        // Reset in the address phase with CSN low: frame discarded
        set_cfg(8, 32, 0, 32);
        frame_bits.delete();
        push_random(20);
        send_frame(1'b0);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) begin
            repeat (4) @(negedge clk_i);
            spi_clk = 1'b1;
            repeat (4) @(negedge clk_i);
            spi_clk = 1'b0;
        end
        repeat (4) @(negedge clk_i);
        spi_csn = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (pkt_valid_o) seen++;
        end
        chk("rst_mid.no_pkt", 64'(seen), 64'd0);
        check_all_zero("rst_mid");

        // Collector resumes normally after that reset
        frame_bits.delete();
        push_random(30);
        run_frame("post_rst", 4, 8, 2, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
